// File: rtl/sar_cycle_seq_if.sv
// Bus between the SAR cycle sequencer and its environment: asynchronous
// phase/strobe inputs, the timeout limit, and the cycle-flag outputs.
interface sar_cycle_seq_if #(
    parameter int NBIT  = 8,
    parameter int TMO_W = 4
);
    logic             CKS;
    logic             RDY;
    logic [TMO_W-1:0] TMO;
    logic [NBIT-1:0]  CF;
    logic             FINAL;
    logic             BUSY;
    logic             TIMEOUT;

    // Environment side drives the analog-facing strobes and the limit.
    modport master (
        output CKS, RDY, TMO,
        input  CF, FINAL, BUSY, TIMEOUT
    );

    // Sequencer side.
    modport slave (
        input  CKS, RDY, TMO,
        output CF, FINAL, BUSY, TIMEOUT
    );
endinterface

// File: rtl/sar_cycle_seq.sv
// SAR bit-cycle sequencer: steps a thermometer of cycle flags on each
// comparator-ready strobe, with an optional per-cycle timeout fallback.
module sar_cycle_seq #(
    parameter int NBIT  = 8,   // legal range 2..16
    parameter int TMO_W = 4
) (
    input  logic           CLK,
    input  logic           RST,
    sar_cycle_seq_if.slave bus
);

    localparam int KW = (NBIT > 1) ? $clog2(NBIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    // Synchronizer + edge-detect chains
    logic r_cks_s1, r_cks_s2, r_cks_s3;
    logic r_rdy_s1, r_rdy_s2, r_rdy_s3;
    logic w_rdy_rise;
    logic w_cks_fall;

    // Sequencer state
    state_t           r_state;
    logic [NBIT-1:0]  r_cf;
    logic [KW-1:0]    r_k;
    logic [TMO_W-1:0] r_cnt;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [NBIT-1:0]  w_cf_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic             w_timeout_nxt;
    logic             w_tmo_hit;
    logic             w_advance;

    // CKS idles high, so its chain resets to 1 and release cannot fake a fall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cks_s1 <= 1'b1;
            r_cks_s2 <= 1'b1;
            r_cks_s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the
            // previous stage's old value, which is what builds the chain.
            r_cks_s1 <= bus.CKS;
            r_cks_s2 <= r_cks_s1;
            r_cks_s3 <= r_cks_s2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdy_s1 <= 1'b0;
            r_rdy_s2 <= 1'b0;
            r_rdy_s3 <= 1'b0;
        end else begin
            r_rdy_s1 <= bus.RDY;
            r_rdy_s2 <= r_rdy_s1;
            r_rdy_s3 <= r_rdy_s2;
        end
    end

    assign w_rdy_rise = r_rdy_s2 & ~r_rdy_s3;
    assign w_cks_fall = ~r_cks_s2 & r_cks_s3;

    // A zero limit disables the timeout path entirely.
    assign w_tmo_hit = (bus.TMO != '0) && (r_cnt == bus.TMO);
    assign w_advance = w_rdy_rise | w_tmo_hit;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // branch below can leave one unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_cf_nxt      = r_cf;
        w_k_nxt       = r_k;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;

        if (r_cks_s2) begin
            // Sample phase overrides everything, including a coincident advance.
            w_state_nxt   = S_IDLE;
            w_cf_nxt      = '0;
            w_k_nxt       = '0;
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cks_fall) begin
                        w_state_nxt   = S_CONV;
                        w_cf_nxt      = '0;
                        w_k_nxt       = '0;
                        w_cnt_nxt     = '0;
                        w_timeout_nxt = 1'b0;
                    end
                end

                S_CONV: begin
                    if (w_advance) begin
                        w_cf_nxt[r_k] = 1'b1;
                        w_k_nxt       = r_k + 1'b1;
                        w_cnt_nxt     = '0;
                        // A coincident RDY edge counts as a normal advance.
                        if (!w_rdy_rise) begin
                            w_timeout_nxt = 1'b1;
                        end
                        if (r_k == KW'(NBIT - 1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    w_cf_nxt = '1;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cf      <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cf      <= w_cf_nxt;
            r_k       <= w_k_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.CF      = r_cf;
    assign bus.BUSY    = (r_state == S_CONV);
    assign bus.FINAL   = (r_state == S_DONE);
    assign bus.TIMEOUT = r_timeout;

endmodule

// File: tb/tb_sar_cycle_seq.sv
// Directed bench for sar_cycle_seq (NBIT=8, TMO_W=4): nominal, timeout,
// coincidence, CKS priority, mid-conversion reset and surplus RDY pulses.
module tb_sar_cycle_seq;

    localparam int NBIT  = 8;
    localparam int TMO_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sar_cycle_seq_if #(.NBIT(NBIT), .TMO_W(TMO_W)) bus ();

    sar_cycle_seq #(.NBIT(NBIT), .TMO_W(TMO_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven and outputs checked 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RDY high 3 clocks then low 3: CF changes exactly on the 3rd edge.
    task automatic rdy_pulse(input string tag, input logic [7:0] cf_before, input logic [7:0] cf_after);
        bus.RDY = 1'b1;
        tick(2);
        check({tag, "_pre"}, 16'(bus.CF), 16'(cf_before));
        tick(1);
        check({tag, "_post"}, 16'(bus.CF), 16'(cf_after));
        bus.RDY = 1'b0;
        tick(3);
    endtask

    function automatic logic [7:0] therm(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.CKS  = 1'b1;
        bus.RDY  = 1'b0;
        bus.TMO  = '0;

        // Reset state
        #1;
        check("rst_cf", 16'(bus.CF), 16'h00);
        check("rst_busy", 16'(bus.BUSY), 16'h0);
        check("rst_final", 16'(bus.FINAL), 16'h0);
        check("rst_timeout", 16'(bus.TIMEOUT), 16'h0);
        tick(3);
        rst = 1'b0;
        tick(4);
        check("idle_busy", 16'(bus.BUSY), 16'h0);

        // Nominal conversion, TMO=0
        bus.TMO = 4'd0;
        bus.CKS = 1'b0;
        tick(2);
        check("nom_busy_pre", 16'(bus.BUSY), 16'h0);
        tick(1);
        check("nom_busy", 16'(bus.BUSY), 16'h1);
        for (int i = 0; i < 8; i++) begin
            rdy_pulse($sformatf("nom_cf%0d", i), therm(i), therm(i + 1));
        end
        check("nom_final", 16'(bus.FINAL), 16'h1);
        check("nom_busy_end", 16'(bus.BUSY), 16'h0);
        check("nom_timeout", 16'(bus.TIMEOUT), 16'h0);
        bus.CKS = 1'b1;
        tick(2);
        check("nom_clr_pre", 16'(bus.FINAL), 16'h1);
        tick(1);
        check("nom_clr_final", 16'(bus.FINAL), 16'h0);
        check("nom_clr_cf", 16'(bus.CF), 16'h00);

        // Stuck comparator, TMO=5: one bit every 6 clocks
        bus.TMO = 4'd5;
        bus.CKS = 1'b0;
        tick(3);
        check("stk_busy", 16'(bus.BUSY), 16'h1);
        for (int i = 0; i < 8; i++) begin
            tick(5);
            check($sformatf("stk_cf%0d_pre", i), 16'(bus.CF), 16'(therm(i)));
            check($sformatf("stk_to%0d_pre", i), 16'(bus.TIMEOUT), (i > 0) ? 16'h1 : 16'h0);
            tick(1);
            check($sformatf("stk_cf%0d_post", i), 16'(bus.CF), 16'(therm(i + 1)));
        end
        check("stk_final", 16'(bus.FINAL), 16'h1);
        check("stk_timeout", 16'(bus.TIMEOUT), 16'h1);
        bus.CKS = 1'b1;
        tick(3);
        check("stk_clr_timeout", 16'(bus.TIMEOUT), 16'h0);
        check("stk_clr_final", 16'(bus.FINAL), 16'h0);

        // Coincident RDY rise and counter==TMO
        bus.TMO = 4'd4;
        bus.CKS = 1'b0;
        tick(3);
        check("coin_busy", 16'(bus.BUSY), 16'h1);
        tick(2);
        bus.RDY = 1'b1;
        tick(2);
        check("coin_cf_pre", 16'(bus.CF), 16'h00);
        tick(1);
        check("coin_cf", 16'(bus.CF), 16'h01);
        check("coin_timeout", 16'(bus.TIMEOUT), 16'h0);
        bus.RDY = 1'b0;
        tick(4);
        check("coin_next_pre", 16'(bus.CF), 16'h01);
        tick(1);
        check("coin_next_cf", 16'(bus.CF), 16'h03);
        check("coin_next_timeout", 16'(bus.TIMEOUT), 16'h1);
        bus.CKS = 1'b1;
        tick(3);

        // CKS priority over an RDY advance during k=3
        bus.TMO = 4'd0;
        bus.CKS = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            rdy_pulse($sformatf("pri_cf%0d", i), therm(i), therm(i + 1));
        end
        bus.CKS = 1'b1;
        bus.RDY = 1'b1;
        tick(2);
        check("pri_cf_pre", 16'(bus.CF), 16'h07);
        tick(1);
        check("pri_cf", 16'(bus.CF), 16'h00);
        check("pri_busy", 16'(bus.BUSY), 16'h0);
        check("pri_final", 16'(bus.FINAL), 16'h0);
        tick(2);
        check("pri_cf_hold", 16'(bus.CF), 16'h00);
        bus.RDY = 1'b0;
        tick(3);

        // Reset mid-conversion
        bus.CKS = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            rdy_pulse($sformatf("mrst_cf%0d", i), therm(i), therm(i + 1));
        end
        rst = 1'b1;
        #1;
        check("mrst_cf_async", 16'(bus.CF), 16'h00);
        check("mrst_busy_async", 16'(bus.BUSY), 16'h0);
        bus.CKS = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        rdy_pulse("mrst_idle0", 8'h00, 8'h00);
        rdy_pulse("mrst_idle1", 8'h00, 8'h00);
        check("mrst_busy_idle", 16'(bus.BUSY), 16'h0);
        bus.CKS = 1'b0;
        tick(3);
        check("mrst_restart_busy", 16'(bus.BUSY), 16'h1);
        rdy_pulse("mrst_restart", 8'h00, 8'h01);
        bus.CKS = 1'b1;
        tick(3);

        // Ten RDY pulses: the 9th and 10th are ignored in DONE
        bus.CKS = 1'b0;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            rdy_pulse($sformatf("xtra_cf%0d", i),
                      (i < 8) ? therm(i) : 8'hFF,
                      (i < 8) ? therm(i + 1) : 8'hFF);
            if (i == 7) begin
                check("xtra_final8", 16'(bus.FINAL), 16'h1);
            end
        end
        check("xtra_final", 16'(bus.FINAL), 16'h1);
        check("xtra_busy", 16'(bus.BUSY), 16'h0);
        check("xtra_timeout", 16'(bus.TIMEOUT), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
